// File: rtl/cmp_sort_pkg.sv
// ----------------------------------------------------------------------------
// cmp_sort_pkg
// Shared definitions for the cmp_sort_ctrl bubble-sort sequencer:
//   state_t     - controller states (IDLE, COMPARE, DONE)
//   ELEM_W      - width of one sorted element
//   SWAP_CNT_W  - width of the saturating swap counter
//   clog2()     - index/pass counter width for N elements (minimum 1)
// ----------------------------------------------------------------------------
package cmp_sort_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int ELEM_W     = 8;
    localparam int SWAP_CNT_W = 8;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cmp_sort_ctrl_comparator8.sv
// ----------------------------------------------------------------------------
// comparator8
// Unsigned magnitude comparator shared by the sort controller.
// Ports:
//   a, b : operands (ELEM_W bits, unsigned)
//   g    : a >  b
//   e    : a == b
//   l    : a <  b
// Exactly one of g/e/l is high at any time.
// ----------------------------------------------------------------------------
module comparator8
    import cmp_sort_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic              g,
    output logic              e,
    output logic              l
);

    assign g = (a > b);
    assign e = (a == b);
    assign l = (a < b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// ----------------------------------------------------------------------------
// cmp_sort_ctrl
// Bubble-sort sequencer: sorts N unsigned bytes using one shared comparator,
// one compare-and-swap per clock.
// Parameters:
//   N        - number of elements (2..8)
//   DESCEND  - 0: ascending (element 0 smallest), 1: descending
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   start      - load request, sampled only in IDLE
//   data_in    - N packed elements, element i = data_in[i*8 +: 8]
//   busy       - high while in COMPARE
//   done       - one-cycle pulse, data_out/swap_count valid
//   data_out   - sorted elements, same packing, held until the next sort ends
//   swap_count - swaps performed by the last sort (saturates at 8'hFF)
// Build option:
//   CMP_SORT_EARLY_EXIT_EN - when defined, a pass with no swaps ends the sort
//   early; otherwise every sort runs N-1 full passes.
// ----------------------------------------------------------------------------
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int N       = 4,
    parameter int DESCEND = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N*ELEM_W-1:0]   data_in,
    output logic                  busy,
    output logic                  done,
    output logic [N*ELEM_W-1:0]   data_out,
    output logic [SWAP_CNT_W-1:0] swap_count
);

    localparam int IDX_W = clog2(N);

    state_t              state_q, state_d;
    logic [ELEM_W-1:0]   elem_q [N];
    logic [ELEM_W-1:0]   elem_d [N];
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_nxt;
    logic [IDX_W-1:0]    pass_q;
    logic [ELEM_W-1:0]   cmp_a, cmp_b;
    logic                cmp_g, cmp_e, cmp_l;
    logic                swap;
    logic                last_pair;
    logic                last_pass;
    logic                end_sort;
    logic [N*ELEM_W-1:0] sorted_flat;
`ifdef CMP_SORT_EARLY_EXIT_EN
    logic                swapped_q;
`endif

    assign idx_nxt = idx_q + 1'b1;
    assign cmp_a   = elem_q[idx_q];
    assign cmp_b   = elem_q[idx_nxt];

    comparator8 u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .g (cmp_g),
        .e (cmp_e),
        .l (cmp_l)
    );

    // Equal operands never swap, which keeps the sort stable.
    assign swap = (state_q == COMPARE) && !cmp_e &&
                  ((DESCEND != 0) ? cmp_l : cmp_g);

    assign last_pair = (idx_q  == IDX_W'(N-2));
    assign last_pass = (pass_q == IDX_W'(N-2));

`ifdef CMP_SORT_EARLY_EXIT_EN
    // The swap happening on the last pair still counts toward this pass.
    assign end_sort = last_pair && (last_pass || !(swapped_q || swap));
`else
    assign end_sort = last_pair && last_pass;
`endif

    assign busy = (state_q == COMPARE);
    assign done = (state_q == DONE);

    // Element array as it will look after this edge; data_out samples it
    // so the final swap is already included when done is raised.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elem_d[i] = elem_q[i];
        end
        if (swap) begin
            elem_d[idx_q]   = cmp_b;
            elem_d[idx_nxt] = cmp_a;
        end
        sorted_flat = '0;
        for (int i = 0; i < N; i++) begin
            sorted_flat[i*ELEM_W +: ELEM_W] = elem_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = COMPARE;
            COMPARE: if (end_sort) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pass_q     <= '0;
            swap_count <= '0;
            data_out   <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                idx_q      <= '0;
                pass_q     <= '0;
                swap_count <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
                swapped_q  <= 1'b0;
`endif
            end else if (state_q == COMPARE) begin
                if (swap && swap_count != '1) begin
                    swap_count <= swap_count + 1'b1;
                end
                if (last_pair) begin
                    idx_q     <= '0;
                    pass_q    <= pass_q + 1'b1;
`ifdef CMP_SORT_EARLY_EXIT_EN
                    swapped_q <= 1'b0;
`endif
                end else begin
                    idx_q     <= idx_nxt;
`ifdef CMP_SORT_EARLY_EXIT_EN
                    if (swap) swapped_q <= 1'b1;
`endif
                end
                if (end_sort) begin
                    data_out <= sorted_flat;
                end
            end
        end
    end

    // Element storage is pure data: loaded on start, rewritten while sorting.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= data_in[i*ELEM_W +: ELEM_W];
            end
        end else if (state_q == COMPARE) begin
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= elem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
module tb_cmp_sort_ctrl;

    localparam int N = 4;
    localparam int LAT_FULL = 10;
`ifdef CMP_SORT_EARLY_EXIT_EN
    localparam int LAT_SORTED = 4;
`else
    localparam int LAT_SORTED = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_d;
    logic [31:0] din_a, din_d;
    logic        busy_a, busy_d, done_a, done_d;
    logic [31:0] dout_a, dout_d;
    logic [7:0]  swc_a, swc_d;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt_a = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_d = '0;

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.N(N), .DESCEND(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data_in(din_a),
        .busy(busy_a), .done(done_a), .data_out(dout_a), .swap_count(swc_a)
    );

    cmp_sort_ctrl #(.N(N), .DESCEND(1)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .data_in(din_d),
        .busy(busy_d), .done(done_d), .data_out(dout_d), .swap_count(swc_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Continuous invariants: busy/done exclusive, data_out stable between done pulses.
    always @(negedge clk) begin
        if (rst) begin
            last_a = '0;
            last_d = '0;
        end else begin
            check("busy_done_excl_a", 32'(busy_a & done_a), 32'd0);
            check("busy_done_excl_d", 32'(busy_d & done_d), 32'd0);
            if (done_a) begin
                last_a = dout_a;
                done_cnt_a++;
            end else begin
                check("dout_hold_a", dout_a, last_a);
            end
            if (done_d) last_d = dout_d;
            else        check("dout_hold_d", dout_d, last_d);
        end
    end

    typedef struct {
        string       name;
        bit          desc;
        logic [31:0] din;
        logic [31:0] dout;
        logic [7:0]  swaps;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    // Pulse start for one cycle, then count edges until done. lat follows the
    // convention "done in cycle k+lat" where k is the start-sampling edge.
    task automatic run_sort(input bit desc, input logic [31:0] din,
                            output logic [31:0] dout, output logic [7:0] swc,
                            output int lat);
        @(negedge clk);
        if (desc) begin din_d = din; start_d = 1'b1; end
        else      begin din_a = din; start_a = 1'b1; end
        @(posedge clk); #1;
        check("busy_after_start", 32'(desc ? busy_d : busy_a), 32'd1);
        @(negedge clk);
        start_a = 1'b0;
        start_d = 1'b0;
        lat = -1;
        dout = 'x;
        swc = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (desc ? done_d : done_a) begin
                lat  = c + 1;
                dout = desc ? dout_d : dout_a;
                swc  = desc ? swc_d : swc_a;
                break;
            end
        end
        @(posedge clk); #1;
        check("done_one_cycle", 32'(desc ? done_d : done_a), 32'd0);
    endtask

    logic [31:0] got_dout;
    logic [7:0]  got_swc;
    int          got_lat;
    int          pulses;

    initial begin
        vecs[0] = '{"reverse",    1'b0, 32'h01020304, 32'h04030201, 8'd6, LAT_FULL};
        vecs[1] = '{"sorted",     1'b0, 32'h04030201, 32'h04030201, 8'd0, LAT_SORTED};
        vecs[2] = '{"ff00ff00",   1'b0, 32'h00FF00FF, 32'hFFFF0000, 8'd3, LAT_FULL};
        vecs[3] = '{"7f80807f",   1'b0, 32'h7F80807F, 32'h80807F7F, 8'd2, LAT_FULL};
        vecs[4] = '{"mixed",      1'b0, 32'h02040103, 32'h04030201, 8'd3, LAT_FULL};
        vecs[5] = '{"all_equal",  1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 8'd0, LAT_SORTED};
        vecs[6] = '{"descend",    1'b1, 32'hAA55F010, 32'h1055AAF0, 8'd4, LAT_FULL};

        rst = 1'b1;
        start_a = 1'b0; start_d = 1'b0;
        din_a = '0; din_d = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_dout",  dout_a, 32'd0);
        check("rst_swc",   32'(swc_a), 32'd0);
        check("rst_dout_d", dout_d, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_sort(vecs[v].desc, vecs[v].din, got_dout, got_swc, got_lat);
            check({vecs[v].name, "_dout"}, got_dout, vecs[v].dout);
            check({vecs[v].name, "_swaps"}, 32'(got_swc), 32'(vecs[v].swaps));
            check({vecs[v].name, "_latency"}, 32'(got_lat), 32'(vecs[v].lat));
        end

        // Reset in the middle of a sort: no done, outputs cleared.
        @(negedge clk);
        din_a = 32'h01020304;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_dout", dout_a, 32'd0);
        check("midrst_swc",  32'(swc_a), 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        pulses = done_cnt_a;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt_a - pulses), 32'd0);
        check("midrst_idle_busy", 32'(busy_a), 32'd0);
        run_sort(1'b0, 32'h01020304, got_dout, got_swc, got_lat);
        check("after_rst_dout",    got_dout, 32'h04030201);
        check("after_rst_swaps",   32'(got_swc), 32'd6);
        check("after_rst_latency", 32'(got_lat), 32'(LAT_FULL));

        // start held high for 20 cycles: one sort per IDLE visit -> two sorts.
        @(negedge clk);
        din_a = 32'h01020304;
        pulses = done_cnt_a;
        start_a = 1'b1;
        repeat (20) @(negedge clk);
        start_a = 1'b0;
        repeat (30) @(negedge clk);
        check("held_start_sorts", 32'(done_cnt_a - pulses), 32'd2);
        check("held_start_dout",  dout_a, 32'h04030201);
        check("held_start_swc",   32'(swc_a), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
Sequencer that sorts N 8-bit values with one shared Comparator8 instance. It uses bubble-sort passes: one compare-and-swap per clock. It accepts a packed vector on a start pulse, steps the comparator across adjacent pairs, and pulses done with the sorted vector and a swap count. It sits between a register-loaded operand source and downstream logic that needs ordered bytes.

Parameters:
N, 4, number of elements; legal range 2..8.
DESCEND, 0, 0 = ascending (element 0 smallest); 1 = descending (element 0 largest).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  load request; sampled only in IDLE
data_in  input  N*8  element i = data_in[i*8 +: 8]
busy  output  1  high while sorting (COMPARE state)
done  output  1  one-cycle pulse, sorted result valid
data_out  output  N*8  sorted elements, same packing; held until next start
swap_count  output  8  number of swaps performed in the last sort

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. On rst: state=IDLE, busy=0, done=0, data_out=0, swap_count=0, pair index=0, pass counter=0, swapped flag=0. Reset mid-sort aborts with no done pulse.
- States: IDLE, COMPARE, DONE.
- IDLE: if start=1 at an edge, load elem[] from data_in, clear swap_count, index=0, pass=0, swapped=0, then go to COMPARE. start=0: stay in IDLE.
- COMPARE: Comparator8 is driven A=elem[index], B=elem[index+1].
  - Swap condition: G=1 when DESCEND=0; L=1 when DESCEND=1.
  - E=1 never swaps, so the sort is stable.
  - On swap at the same edge: exchange the two elements, increment swap_count (saturate at 8'hFF), set swapped=1.
  - index advances 0..N-2. At index=N-2 the pass ends: index=0, pass+1, swapped cleared.
- Pass termination: after pass N-2 completes (N-1 passes total), go to DONE. Early exit is governed by the Optional Feature.
- DONE: done=1 for exactly one cycle, busy=0, data_out already updated. Next state is IDLE.
- data_out: registered view of elem[]. It updates only on the transition into DONE, so it never shows partial sorts.
- Latency: start sampled at edge k. Without early exit, done is high in cycle k+1+(N-1)^2, i.e. cycle k+10 for N=4.
- start while busy or done: ignored, with no effect on state.
- busy and done are never high together.

Optional Feature:
Macro CMP_SORT_EARLY_EXIT_EN.
- Defined: at the end of any pass with swapped=0, go directly to DONE. Already-sorted N=4 input gives done at k+4.
- Undefined: always N-1 full passes, fixed latency (N-1)^2+1 cycles. The swapped flag may be removed.

Decomposition:
- Package cmp_sort_pkg: state enum (IDLE, COMPARE, DONE); localparam ELEM_W=8; localparam SWAP_CNT_W=8; index/pass width function clog2(N).
- Sub-module: the existing Comparator8, instantiated once as the shared compare resource.
- Swap/mux logic stays inline in the controller.

Test Plan:
- Reset during sort: start with data_in=32'h01020304 (N=4, elem0=04), assert rst at cycle k+3 -> busy=0, done never pulses, data_out=0, swap_count=0; next start sorts normally.
- Reverse order: elem0..3 = 04,03,02,01, DESCEND=0 -> done at k+10, data_out elems = 01,02,03,04, swap_count=6.
- Already sorted, CMP_SORT_EARLY_EXIT_EN defined: elems 01,02,03,04 -> done at k+4, swap_count=0. Same input with the macro undefined -> done at k+10.
- Duplicates and extremes: elems FF,00,FF,00 -> 00,00,FF,FF, swap_count=3; elems 7F,80,80,7F -> 7F,7F,80,80 (unsigned magnitude).
- DESCEND=1: elems 10,F0,55,AA -> F0,AA,55,10, done at k+10 (early exit disabled).
- start held high for 20 cycles -> exactly one sort per IDLE visit. busy never coincides with done, and data_out holds stable between done pulses.
